// File: rtl/rob_commit_unit_pkg.sv
// ---------------------------------------------------------------------------
// rob_pkg
// Types and constants shared by the reorder buffer, its producers
// (datain_issue / datain_update) and the commit unit.
//   rob_entry_t    - packed ROB entry, MSB first
//   commit_state_e - retirement FSM states
//   ROB_IDX_W      - ROB index (tag) width
//   ROB_ENTRY_W    - entry width
// ---------------------------------------------------------------------------
package rob_pkg;

    localparam int ROB_IDX_W   = 5;
    localparam int ROB_ENTRY_W = 64;

    typedef struct packed {
        logic        ready;
        logic        wb;
        logic        store;
        logic        mispredict;
        logic [4:0]  rd;
        logic [22:0] rsvd;
        logic [31:0] value;   // result, or redirect target for a mispredict
    } rob_entry_t;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        STORE_WAIT = 2'd1,
        FLUSH      = 2'd2
    } commit_state_e;

endpackage

// File: rtl/rob_commit_unit.sv
// ---------------------------------------------------------------------------
// rob_commit_unit
// Retires the ROB head entry in program order: regfile writeback with RAT
// tag release, store commit handshake, and flush/redirect on mispredicted
// branches. Sole driver of the queue's commit strobe.
//
// Optional feature macro: ROB_COMMIT_PERF_EN adds the perf_retired and
// perf_stall counters (32-bit, wrap modulo 2^32).
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   head_entry         entry at the queue commit pointer
//   head_idx           commit pointer value (ROB tag of the head)
//   q_empty            queue empty flag
//   commit             one-cycle strobe, queue advances at next edge
//   rf_we/rd/data/tag  regfile writeback and RAT tag release
//   st_req/st_tag      store commit request, held until st_ack
//   st_ack             store performed
//   flush, redirect_pc one-cycle flush and fetch redirect target
//   perf_retired/stall performance counters (macro builds only)
// ---------------------------------------------------------------------------
module rob_commit_unit
    import rob_pkg::*;
#(
    parameter int ENTRY_W = ROB_ENTRY_W,
    parameter int IDX_W   = ROB_IDX_W,
    parameter int REG_W   = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [ENTRY_W-1:0] head_entry,
    input  logic [IDX_W-1:0]   head_idx,
    input  logic               q_empty,
    output logic               commit,
    output logic               rf_we,
    output logic [REG_W-1:0]   rf_rd,
    output logic [31:0]        rf_data,
    output logic [IDX_W-1:0]   rf_tag,
    output logic               st_req,
    output logic [IDX_W-1:0]   st_tag,
    input  logic               st_ack,
    output logic               flush,
`ifdef ROB_COMMIT_PERF_EN
    output logic [31:0]        redirect_pc,
    output logic [31:0]        perf_retired,
    output logic [31:0]        perf_stall
`else
    output logic [31:0]        redirect_pc
`endif
);

    commit_state_e r_state;
    commit_state_e w_next;
    rob_entry_t    w_entry;
    logic          w_unused_rsvd;

    assign w_entry       = rob_entry_t'(head_entry);
    assign w_unused_rsvd = ^w_entry.rsvd;

    // Outputs are a pure function of state and head; reset forces them
    // low in the reset cycle so an outstanding st_req drops immediately.
    always_comb begin
        w_next      = r_state;
        commit      = 1'b0;
        rf_we       = 1'b0;
        rf_rd       = '0;
        rf_data     = '0;
        rf_tag      = '0;
        st_req      = 1'b0;
        st_tag      = '0;
        flush       = 1'b0;
        redirect_pc = '0;

        case (r_state)
            IDLE: begin
                if (!q_empty && w_entry.ready) begin
                    // Type priority: store > mispredict > writeback
                    if (w_entry.store) begin
                        st_req = 1'b1;
                        st_tag = head_idx;
                        w_next = STORE_WAIT;
                    end else if (w_entry.mispredict) begin
                        commit      = 1'b1;
                        flush       = 1'b1;
                        redirect_pc = w_entry.value;
                        w_next      = FLUSH;
                    end else begin
                        commit = 1'b1;
                        if (w_entry.wb && (w_entry.rd != '0)) begin
                            rf_we   = 1'b1;
                            rf_rd   = w_entry.rd;
                            rf_data = w_entry.value;
                            rf_tag  = head_idx;
                        end
                    end
                end
            end
            STORE_WAIT: begin
                // Head cannot move while waiting, so head_idx is stable.
                st_req = 1'b1;
                st_tag = head_idx;
                if (st_ack) begin
                    commit = 1'b1;
                    w_next = IDLE;
                end
            end
            FLUSH: begin
                // Bubble while queue and RAT recover.
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase

        if (rst) begin
            commit      = 1'b0;
            rf_we       = 1'b0;
            rf_rd       = '0;
            rf_data     = '0;
            rf_tag      = '0;
            st_req      = 1'b0;
            st_tag      = '0;
            flush       = 1'b0;
            redirect_pc = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

`ifdef ROB_COMMIT_PERF_EN
    logic [31:0] r_perf_retired;
    logic [31:0] r_perf_stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_retired <= '0;
            r_perf_stall   <= '0;
        end else begin
            if (commit) begin
                r_perf_retired <= r_perf_retired + 32'd1;
            end
            if (!q_empty && !commit) begin
                r_perf_stall <= r_perf_stall + 32'd1;
            end
        end
    end

    assign perf_retired = r_perf_retired;
    assign perf_stall   = r_perf_stall;
`endif

endmodule
